// File: rtl/afbc_block_expander.sv
// Expands one compressed AFBC block word (solid or raw) into a serial stream of 32-bit RGBA pixels.
// Optional perf counters are built only when AFBC_EXP_PERF_EN is defined; otherwise perf_* read as zero.
module afbc_block_expander #(
  parameter int PIX_W   = 32,
  parameter int DATA_W  = 1024,
  parameter int BLK_PIX = 32,
  parameter int RAW_MAX = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmp_valid,
  input  logic [DATA_W-1:0] cmp_data,
  output logic              cmp_ready,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_last,
  input  logic              pix_ready,
  output logic              err_bad_block,
  output logic [31:0]       perf_blocks,
  output logic [31:0]       perf_pixels
);

  localparam int MODE_LSB = DATA_W - 8;
  localparam int PAY_W    = RAW_MAX * PIX_W;

  typedef enum logic [1:0] {IDLE, EXPAND, DROP} state_t;

  state_t                         r_state;
  logic [BLK_PIX-1:0][PIX_W-1:0]  r_pix;
  logic                           r_solid;
  logic [5:0]                     r_count;
  logic [4:0]                     r_idx;
  logic                           r_pix_valid;
  logic                           r_pix_last;
  logic [PIX_W-1:0]               r_pix_data;
  logic                           r_err;

  logic [7:0]       w_mode;
  logic [23:0]      w_size;
  logic [4:0]       w_raw_n;
  logic             w_raw_ok;
  logic             w_accept;
  logic             w_hs;
  logic [4:0]       w_idx_nxt;
  logic             w_last_nxt;
  logic [PIX_W-1:0] w_pix_nxt;

  assign w_mode   = cmp_data[DATA_W-1 -: 8];
  assign w_size   = cmp_data[MODE_LSB-1 -: 24];
  assign w_raw_n  = w_size[6:2];
  // Legal raw size: multiple of 4 bytes, 1..31 pixels (size < 128 keeps n within 5 bits).
  assign w_raw_ok = (w_size[1:0] == 2'b00) && (w_size[23:7] == '0) && (w_raw_n != 5'd0);

  assign cmp_ready = (r_state == IDLE) && !rst;
  assign w_accept  = cmp_valid && cmp_ready;
  assign w_hs      = r_pix_valid && pix_ready;

  assign w_idx_nxt  = r_idx + 5'd1;
  assign w_last_nxt = ({1'b0, w_idx_nxt} == (r_count - 6'd1));
  assign w_pix_nxt  = r_solid ? r_pix[0] : r_pix[w_idx_nxt];

  assign pix_valid     = r_pix_valid;
  assign pix_data      = r_pix_data;
  assign pix_last      = r_pix_last;
  assign err_bad_block = r_err;

  // Payload storage needs no reset: it is only read after a fresh word is latched.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pix <= {{PIX_W{1'b0}}, cmp_data[PAY_W-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_solid     <= 1'b0;
      r_count     <= '0;
      r_idx       <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
      r_pix_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_mode == 8'h00) begin
              r_solid     <= 1'b1;
              r_count     <= 6'(BLK_PIX);
              r_idx       <= '0;
              r_pix_valid <= 1'b1;
              r_pix_last  <= 1'b0;
              r_pix_data  <= cmp_data[PIX_W-1:0];
              r_state     <= EXPAND;
            end else if ((w_mode == 8'h01) && w_raw_ok) begin
              r_solid     <= 1'b0;
              r_count     <= {1'b0, w_raw_n};
              r_idx       <= '0;
              r_pix_valid <= 1'b1;
              r_pix_last  <= (w_raw_n == 5'd1);
              r_pix_data  <= cmp_data[PIX_W-1:0];
              r_state     <= EXPAND;
            end else begin
              r_err   <= 1'b1;
              r_state <= DROP;
            end
          end
        end
        EXPAND: begin
          if (w_hs) begin
            if (r_pix_last) begin
              r_pix_valid <= 1'b0;
              r_pix_last  <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_idx      <= w_idx_nxt;
              r_pix_data <= w_pix_nxt;
              r_pix_last <= w_last_nxt;
            end
          end
        end
        DROP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef AFBC_EXP_PERF_EN
  logic [31:0] r_perf_blocks;
  logic [31:0] r_perf_pixels;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_blocks <= '0;
      r_perf_pixels <= '0;
    end else if (w_hs) begin
      r_perf_pixels <= r_perf_pixels + 32'd1;
      if (r_pix_last) begin
        r_perf_blocks <= r_perf_blocks + 32'd1;
      end
    end
  end

  assign perf_blocks = r_perf_blocks;
  assign perf_pixels = r_perf_pixels;
`else
  assign perf_blocks = '0;
  assign perf_pixels = '0;
`endif

endmodule

// File: tb/tb_afbc_block_expander.sv
// Scoreboard bench: stimulus pushes model-predicted pixels, a negedge monitor pops and compares them.
module tb_afbc_block_expander;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmp_valid;
  logic [1023:0] cmp_data;
  logic          cmp_ready;
  logic          pix_valid;
  logic [31:0]   pix_data;
  logic          pix_last;
  logic          pix_ready;
  logic          err_bad_block;
  logic [31:0]   perf_blocks;
  logic [31:0]   perf_pixels;

  always #5 clk = ~clk;

  afbc_block_expander dut (
    .clk(clk), .rst(rst), .cmp_valid(cmp_valid), .cmp_data(cmp_data), .cmp_ready(cmp_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last), .pix_ready(pix_ready),
    .err_bad_block(err_bad_block), .perf_blocks(perf_blocks), .perf_pixels(perf_pixels)
  );

  typedef struct packed { logic [31:0] d; logic l; } pix_t;
  pix_t exp_q[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, hs_cnt = 0, err_seen = 0;
  int exp_err = 0, exp_blocks = 0, exp_pixels = 0;
  int rdy_mode = 0, rdy_ptr = 0;
  int acc_cyc = 0, acc_cyc_prev = 0;
  logic [3:0] rdy_pat = 4'b1001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #2;
  endtask

  // Reference model: expected pixel list straight from the block format rules.
  task automatic model(input logic [1023:0] w, output int n);
    logic [7:0] mode;
    int size;
    pix_t p;
    mode = w[1023:1016];
    size = int'(w[1015:992]);
    n = 0;
    if (mode == 8'h00) n = 32;
    else if (mode == 8'h01 && size % 4 == 0 && size / 4 >= 1 && size / 4 <= 31) n = size / 4;
    for (int i = 0; i < n; i++) begin
      p.d = (mode == 8'h00) ? w[31:0] : w[i*32 +: 32];
      p.l = (i == n - 1);
      exp_q.push_back(p);
    end
    if (n == 0) exp_err++;
    else begin
      exp_blocks++;
      exp_pixels += n;
    end
  endtask

  function automatic logic [1023:0] mk(input logic [7:0] mode, input logic [23:0] size,
                                       input logic [991:0] pl);
    return {mode, size, pl};
  endfunction

  function automatic logic [991:0] rand_pl();
    logic [991:0] pl;
    for (int i = 0; i < 31; i++) pl[i*32 +: 32] = $urandom();
    return pl;
  endfunction

  task automatic send(input logic [1023:0] w);
    int n;
    int t;
    model(w, n);
    wait_neg();
    cmp_data  = w;
    cmp_valid = 1'b1;
    t = 0;
    while (!cmp_ready && t < 3000) begin
      wait_neg();
      t++;
    end
    chk("cmp_ready_wait", {31'd0, cmp_ready}, 32'd1);
    acc_cyc_prev = acc_cyc;
    acc_cyc = cyc;
    @(posedge clk);
    #1 cmp_valid = 1'b0;
    wait_neg();
    if (n > 0) chk("latency_pix_valid", {31'd0, pix_valid}, 32'd1);
    else begin
      chk("drop_err_pulse", {31'd0, err_bad_block}, 32'd1);
      chk("drop_no_pix_valid", {31'd0, pix_valid}, 32'd0);
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef AFBC_EXP_PERF_EN
    chk({tag, "_perf_blocks"}, perf_blocks, 32'(exp_blocks));
    chk({tag, "_perf_pixels"}, perf_pixels, 32'(exp_pixels));
`else
    chk({tag, "_perf_blocks_off"}, perf_blocks, 32'd0);
    chk({tag, "_perf_pixels_off"}, perf_pixels, 32'd0);
`endif
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || pix_valid || !cmp_ready) && t < 5000) begin
      wait_neg();
      t++;
    end
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_err_count"}, 32'(err_seen), 32'(exp_err));
    check_perf(tag);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: pix_ready = 1'b1;
      1: pix_ready = 1'($urandom_range(0, 1));
      default: begin
        pix_ready = rdy_pat[rdy_ptr % 4];
        rdy_ptr++;
      end
    endcase
  end

  logic        prev_v, prev_hs, prev_last_hs, prev_err, prev_l;
  logic [31:0] prev_d;
  initial begin
    prev_v = 0; prev_hs = 0; prev_last_hs = 0; prev_err = 0; prev_l = 0; prev_d = 0;
  end

  always @(negedge clk) begin
    pix_t p;
    cyc++;
    if (rst) begin
      prev_v = 0; prev_hs = 0; prev_last_hs = 0; prev_err = 0;
    end else begin
      if (pix_valid) chk("cmp_ready_low_in_expand", {31'd0, cmp_ready}, 32'd0);
      if (prev_last_hs) begin
        chk("cmp_ready_after_last", {31'd0, cmp_ready}, 32'd1);
        chk("pix_valid_after_last", {31'd0, pix_valid}, 32'd0);
      end
      if (prev_v && !prev_hs) begin
        chk("stall_valid_held", {31'd0, pix_valid}, 32'd1);
        chk("stall_data_held", pix_data, prev_d);
        chk("stall_last_held", {31'd0, pix_last}, {31'd0, prev_l});
      end
      if (err_bad_block) begin
        err_seen++;
        chk("err_single_cycle", {31'd0, prev_err}, 32'd0);
        chk("err_no_pixel", {31'd0, pix_valid}, 32'd0);
      end
      if (pix_valid && pix_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pixel: actual=%h required=none", pix_data);
        end else begin
          p = exp_q.pop_front();
          chk("pix_data", pix_data, p.d);
          chk("pix_last", {31'd0, pix_last}, {31'd0, p.l});
        end
      end
      prev_v       = pix_valid;
      prev_hs      = pix_valid && pix_ready;
      prev_last_hs = pix_valid && pix_ready && pix_last;
      prev_err     = err_bad_block;
      prev_d       = pix_data;
      prev_l       = pix_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [991:0] pl;
    int base;
    int t;
    int r;
    int n;
    rst = 1'b1; cmp_valid = 1'b0; cmp_data = '0; pix_ready = 1'b0;
    repeat (3) wait_neg();
    chk("reset_cmp_ready", {31'd0, cmp_ready}, 32'd0);
    chk("reset_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("reset_pix_data", pix_data, 32'd0);
    chk("reset_pix_last", {31'd0, pix_last}, 32'd0);
    chk("reset_err", {31'd0, err_bad_block}, 32'd0);
    chk("reset_perf_blocks", perf_blocks, 32'd0);
    chk("reset_perf_pixels", perf_pixels, 32'd0);
    rst = 1'b0;
    wait_neg();
    chk("idle_cmp_ready", {31'd0, cmp_ready}, 32'd1);

    // Solid block
    rdy_mode = 0;
    send(mk(8'h00, 24'h000123, {960'd0, 32'hAABBCCDD}));
    drain("solid");

    // Raw full: 31 pixels 0x100..0x11E
    for (int i = 0; i < 31; i++) pl[i*32 +: 32] = 32'(i + 256);
    send(mk(8'h01, 24'h00007C, pl));
    drain("raw_full");

    // Raw short with backpressure
    rdy_mode = 2;
    rdy_ptr  = 0;
    send(mk(8'h01, 24'h000008, rand_pl()));
    drain("raw_short");

    // Bad blocks
    rdy_mode = 0;
    send(mk(8'h05, 24'h000010, rand_pl()));
    send(mk(8'h01, 24'h000006, rand_pl()));
    send(mk(8'h01, 24'h000000, rand_pl()));
    drain("bad_blocks");

    // Back-to-back solids: 32 pixel cycles + 1 idle cycle per block
    send(mk(8'h00, 24'h0, {960'd0, 32'h01020304}));
    send(mk(8'h00, 24'h0, {960'd0, 32'h05060708}));
    chk("b2b_period", 32'(acc_cyc - acc_cyc_prev), 32'd33);
    drain("b2b");

    // Reset after 10 solid pixels
    base = hs_cnt;
    send(mk(8'h00, 24'h0, {960'd0, 32'h11223344}));
    t = 0;
    while (hs_cnt < base + 10 && t < 200) begin
      wait_neg();
      t++;
    end
    chk("pre_reset_pixels", 32'(hs_cnt - base), 32'd10);
    rst = 1'b1;
    #1;
    chk("midrst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("midrst_cmp_ready", {31'd0, cmp_ready}, 32'd0);
    chk("midrst_pix_last", {31'd0, pix_last}, 32'd0);
    exp_q.delete();
    exp_blocks = 0; exp_pixels = 0; exp_err = 0; err_seen = 0;
    wait_neg();
    wait_neg();
    rst = 1'b0;
    wait_neg();
    chk("post_reset_perf_blocks", perf_blocks, 32'd0);
    chk("post_reset_perf_pixels", perf_pixels, 32'd0);
    send(mk(8'h00, 24'h0, {960'd0, 32'h55667788}));
    drain("after_reset");

    // Randomized mix with random backpressure
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) send(mk(8'h00, 24'($urandom()), rand_pl()));
      else if (r <= 7) begin
        n = $urandom_range(1, 31);
        send(mk(8'h01, 24'(n * 4), rand_pl()));
      end else if (r == 8) send(mk(8'h01, 24'($urandom_range(0, 255)), rand_pl()));
      else send(mk(8'($urandom_range(2, 255)), 24'($urandom_range(4, 124)), rand_pl()));
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/afbc_block_expander.md
# afbc_block_expander

Downstream consumer of the AFBC compressor's output stream. Accepts one 1024-bit compressed block word per handshake, decodes its header, and expands it into a serial stream of 32-bit RGBA pixels for the display/texture fetch path. Supports solid-colour (mode 0x00) and raw (mode 0x01) blocks. Any other mode is counted as an error and dropped.

## Interface
- PIX_W, 32, pixel width in bits
- DATA_W, 1024, compressed word width
- BLK_PIX, 32, pixels emitted for a solid block
- RAW_MAX, 31, max raw pixels per word (payload bits [991:0] / PIX_W)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset; one clock domain
- cmp_valid  in  1  compressed word valid
- cmp_data  in  DATA_W  header [1023:1016]=mode, [1015:992]=payload size in bytes; payload [991:0]
- cmp_ready  out  1  expander can accept a word
- pix_valid  out  1  pixel valid
- pix_data  out  PIX_W  pixel value
- pix_last  out  1  final pixel of the current block
- pix_ready  in  1  downstream accepts pixel
- err_bad_block  out  1  one-cycle pulse on a dropped block
- perf_blocks  out  32  blocks expanded successfully
- perf_pixels  out  32  pixels handed off

## Operation
- States: IDLE, EXPAND, DROP.
- IDLE: cmp_ready=1 (combinational, state==IDLE). On cmp_valid&&cmp_ready, latch the word, then decode:
  - mode 0x00: count=BLK_PIX; every pixel=cmp_data[31:0]; size field ignored -> EXPAND.
  - mode 0x01: n=size>>2. Legal iff size[1:0]==0 and 1<=n<=RAW_MAX. Pixel i=cmp_data[i*32 +: 32], i=0..n-1 -> EXPAND. Illegal -> DROP.
  - any other mode -> DROP.
- EXPAND: pix_valid=1. pix_data/pix_last held stable until pix_ready. Index advances on each pix_valid&&pix_ready. pix_last=1 only when index==count-1. Handshake on last pixel -> IDLE; perf_blocks+=1.
- DROP: one cycle; err_bad_block=1 -> IDLE. No pixels emitted; perf counters unchanged.
- perf_pixels += 1 per pixel handshake.
- Counters are 32-bit and wrap modulo 2^32 with no saturation.
- Index is a 5-bit counter; count is stored as 6 bits (max 32).
- Reset values: cmp_ready=0 while rst is asserted, 1 in IDLE after release. pix_valid=0, pix_data=0, pix_last=0, err_bad_block=0, perf_blocks=0, perf_pixels=0; state=IDLE.
- Reset mid-block: the partial block is discarded immediately and no further pixels of that block appear.

## Timing
- Word accepted at edge T -> pix_valid=1 from T+1 (1-cycle latency). DROP case: err_bad_block high in cycle T+1.
- Throughput: 1 pixel/cycle while pix_ready=1.
- Back-to-back solid blocks with pix_ready stuck at 1: 32 pixel cycles + 1 IDLE cycle per block.
- cmp_ready=0 throughout EXPAND and DROP. No word is accepted in the same cycle as the last pixel handshake.
- pix_valid never drops without a handshake (AXI-style). pix_ready may toggle freely.
- pix_data, pix_last and pix_valid are registered outputs.

## Configuration
- AFBC_EXP_PERF_EN defined: perf_blocks/perf_pixels counters are implemented as described.
- AFBC_EXP_PERF_EN undefined: both outputs are tied to 0 and no counter flops are inferred. err_bad_block is unaffected.

## Test plan
- Solid: mode 0x00, pixel 0xAABBCCDD, pix_ready=1 -> 32 beats of 0xAABBCCDD, pix_last only on beat 32, perf_blocks=1, perf_pixels=32.
- Raw full: mode 0x01, size 0x00007C, word i=i+0x100 -> 31 beats 0x100..0x11E, pix_last on 0x11E.
- Raw short + backpressure: size 8, pix_ready toggling 1,0,0,1 -> 2 pixels; pix_data held stable while stalled; cmp_ready=0 until the cycle after the last handshake.
- Bad blocks: mode 0x05, then mode 0x01 with size 6, then mode 0x01 with size 0 -> each gives one err_bad_block pulse, no pix_valid, perf unchanged.
- Reset mid-block: assert rst after 10 solid pixels -> pix_valid=0 immediately; after release, the next block streams from pixel 0; perf=0.
- Macro off: rebuild without AFBC_EXP_PERF_EN, run the solid test -> perf outputs stay 0, pixel stream identical.
